// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared IEEE-754 single-precision types and constants for fp_diff.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          FP_BIAS    = 127;
  localparam int          MAN_W      = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    NORM  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_unpack.sv
// ============================================================================
// Module   : fp_unpack
// Purpose  : Splits a single-precision word into sign, exponent and a 24-bit
//            mantissa with hidden bit; denormals are flushed to zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      op,
  output logic             sign,
  output logic [7:0]       exp,
  output logic [MAN_W-1:0] man,
  output logic             is_zero,
  output logic             is_special
);

  fp32_t w_op;

  always_comb begin
    w_op       = fp32_t'(op);
    sign       = w_op.sign;
    is_zero    = (w_op.exp == 8'd0);
    is_special = (w_op.exp == FP_EXP_MAX);
    exp        = w_op.exp;
    man        = is_zero ? '0 : {1'b1, w_op.man};
  end

endmodule

`default_nettype wire

// File: rtl/fp_diff.sv
// ============================================================================
// Module   : fp_diff
// Purpose  : Streaming single-precision differentiator y[n] = x[n] - x[n-1],
//            align/add/normalize FSM, truncation rounding.
//            Optional macro FP_DIFF_DROP_CNT_EN adds a saturating drop counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_diff
  import fp_pkg::*;
#(
  parameter logic [31:0] PREV_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [31:0] value,
  output logic        rdy,
  output logic [31:0] res,
  output logic        res_vld,
  output logic        exception
`ifdef FP_DIFF_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_prev;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;

  logic             r_a_sign;
  logic [7:0]       r_a_exp;
  logic [MAN_W-1:0] r_a_man;
  logic             r_b_sign;
  logic [MAN_W-1:0] r_b_man;
  logic             r_special;

  logic [MAN_W:0]   r_sum;
  logic             r_sign;
  logic [7:0]       r_exp;

  logic             w_ua_sign, w_ua_zero, w_ua_special;
  logic [7:0]       w_ua_exp;
  logic [MAN_W-1:0] w_ua_man;
  logic             w_ub_sign, w_ub_zero, w_ub_special;
  logic [7:0]       w_ub_exp;
  logic [MAN_W-1:0] w_ub_man;

  fp_unpack u_unpack_a (
    .op         (r_op_a),
    .sign       (w_ua_sign),
    .exp        (w_ua_exp),
    .man        (w_ua_man),
    .is_zero    (w_ua_zero),
    .is_special (w_ua_special)
  );

  fp_unpack u_unpack_b (
    .op         (r_op_b),
    .sign       (w_ub_sign),
    .exp        (w_ub_exp),
    .man        (w_ub_man),
    .is_zero    (w_ub_zero),
    .is_special (w_ub_special)
  );

  // Alignment: A is the larger magnitude, B is shifted right by the exponent gap.
  logic             w_swap;
  logic             w_big_sign, w_small_sign, w_small_zero;
  logic [7:0]       w_big_exp, w_small_exp, w_diff;
  logic [MAN_W-1:0] w_big_man, w_small_man, w_small_shifted;

  always_comb begin
    w_swap          = {w_ub_exp, w_ub_man} > {w_ua_exp, w_ua_man};
    w_big_sign      = w_swap ? w_ub_sign : w_ua_sign;
    w_big_exp       = w_swap ? w_ub_exp  : w_ua_exp;
    w_big_man       = w_swap ? w_ub_man  : w_ua_man;
    w_small_sign    = w_swap ? w_ua_sign : w_ub_sign;
    w_small_exp     = w_swap ? w_ua_exp  : w_ub_exp;
    w_small_man     = w_swap ? w_ua_man  : w_ub_man;
    w_small_zero    = w_swap ? w_ua_zero : w_ub_zero;
    w_diff          = w_big_exp - w_small_exp;
    w_small_shifted = (w_small_zero || (w_diff > 8'd24)) ? '0 : (w_small_man >> w_diff);
  end

  logic [8:0] w_exp_inc;
  logic       w_norm_done;

  always_comb begin
    w_exp_inc   = {1'b0, r_exp} + 9'd1;
    w_norm_done = r_special || r_sum[MAN_W] || (r_sum == '0) ||
                  r_sum[MAN_W-1] || (r_exp <= 8'd1);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (vld) w_state_next = ALIGN;
      ALIGN:   w_state_next = ADD;
      ADD:     w_state_next = NORM;
      NORM:    if (w_norm_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  assign rdy = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= PREV_INIT;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_a_sign  <= 1'b0;
      r_a_exp   <= '0;
      r_a_man   <= '0;
      r_b_sign  <= 1'b0;
      r_b_man   <= '0;
      r_special <= 1'b0;
      r_sum     <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      res       <= '0;
      res_vld   <= 1'b0;
      exception <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (vld) begin
            r_op_a <= value;
            r_op_b <= {~r_prev[31], r_prev[30:0]};
            r_prev <= value;
          end
        end
        ALIGN: begin
          r_a_sign  <= w_big_sign;
          r_a_exp   <= w_big_exp;
          r_a_man   <= w_big_man;
          r_b_sign  <= w_small_sign;
          r_b_man   <= w_small_shifted;
          r_special <= w_ua_special || w_ub_special;
        end
        ADD: begin
          r_sum  <= (r_a_sign == r_b_sign) ? ({1'b0, r_a_man} + {1'b0, r_b_man})
                                           : ({1'b0, r_a_man} - {1'b0, r_b_man});
          r_sign <= r_a_sign;
          r_exp  <= r_a_exp;
        end
        NORM: begin
          if (r_special) begin
            res       <= FP_QNAN;
            exception <= 1'b1;
            res_vld   <= 1'b1;
          end else if (r_sum[MAN_W]) begin
            res_vld <= 1'b1;
            if (w_exp_inc >= {1'b0, FP_EXP_MAX}) begin
              res       <= FP_QNAN;
              exception <= 1'b1;
            end else begin
              res       <= {r_sign, w_exp_inc[7:0], r_sum[MAN_W-1:1]};
              exception <= 1'b0;
            end
          end else if (r_sum == '0) begin
            res       <= '0;
            exception <= 1'b0;
            res_vld   <= 1'b1;
          end else if (r_sum[MAN_W-1]) begin
            res       <= {r_sign, r_exp, r_sum[MAN_W-2:0]};
            exception <= 1'b0;
            res_vld   <= 1'b1;
          end else if (r_exp > 8'd1) begin
            // One left-normalize step per cycle until the hidden bit lands.
            r_sum <= {r_sum[MAN_W-1:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end else begin
            res       <= '0;
            exception <= 1'b0;
            res_vld   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_DIFF_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                        drop_cnt <= '0;
    else if (vld && !rdy && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire
